// File: rtl/matrix_io_sequencer.sv
// Job sequencer: receives 2N operand vectors into vector memory, runs the multiply core, then reads back and transmits N results.
// Every output is registered or decoded from state; the block waits on rising edges of the comm and multiply flags.
module matrix_io_sequencer #(
  parameter int MATRIX_N = 4,
  parameter int HEADER = 1,
  localparam int DATA_WIDTH = HEADER*8 + 32*MATRIX_N,
  localparam int ADDR_W = $clog2(3*MATRIX_N)
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  run,
  input  logic                  comm_rx_complete,
  input  logic                  comm_tx_complete,
  input  logic [DATA_WIDTH-1:0] comm_rx_data,
  output logic                  comm_op,
  output logic                  comm_start,
  output logic [DATA_WIDTH-1:0] comm_tx_data,
  output logic                  mem_we,
  output logic                  mem_re,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  mult_start,
  input  logic                  mult_done,
  output logic                  busy,
  output logic                  job_done,
  output logic                  job_err
);

  localparam int CNT_W = $clog2(2*MATRIX_N);
  localparam int HW = HEADER*8;

  typedef enum logic [3:0] {
    IDLE, RX_ARM, RX_WAIT, RX_STORE, MULT_START, MULT_WAIT,
    TX_READ, TX_LATCH, TX_ARM, TX_WAIT, DONE
  } state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      vec_cnt_q;
  logic [DATA_WIDTH-1:0] cap_q;
  logic                  rx_prev, tx_prev, md_prev;
  logic                  rx_rise, tx_rise, md_rise;
  logic [HW-1:0]         hdr;
  logic                  hdr_bad, last_rx, last_tx;

  assign rx_rise = comm_rx_complete & ~rx_prev;
  assign tx_rise = comm_tx_complete & ~tx_prev;
  assign md_rise = mult_done & ~md_prev;

  // Header holds the entry count; zero or more than MATRIX_N entries is malformed.
  assign hdr     = comm_rx_data[DATA_WIDTH-1 -: HW];
  assign hdr_bad = (hdr == '0) || (32'(hdr) > 32'(MATRIX_N));
  assign last_rx = (vec_cnt_q == CNT_W'(2*MATRIX_N-1));
  assign last_tx = (vec_cnt_q == CNT_W'(MATRIX_N-1));

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:       if (run) state_d = RX_ARM;
      RX_ARM:     state_d = RX_WAIT;
      RX_WAIT:    if (rx_rise) state_d = hdr_bad ? DONE : RX_STORE;
      RX_STORE:   state_d = last_rx ? MULT_START : RX_ARM;
      MULT_START: state_d = MULT_WAIT;
      MULT_WAIT:  if (md_rise) state_d = TX_READ;
      TX_READ:    state_d = TX_LATCH;
      TX_LATCH:   state_d = TX_ARM;
      TX_ARM:     state_d = TX_WAIT;
      TX_WAIT:    if (tx_rise) state_d = last_tx ? DONE : TX_READ;
      DONE:       state_d = IDLE;
      default:    state_d = IDLE;
    endcase
  end

  always_comb begin
    comm_start = (state_q == RX_ARM) || (state_q == TX_ARM);
    mem_we     = (state_q == RX_STORE);
    mem_re     = (state_q == TX_READ);
    mem_wdata  = (state_q == RX_STORE) ? cap_q : '0;
    mult_start = (state_q == MULT_START);
    busy       = (state_q != IDLE);
    job_done   = (state_q == DONE);
    mem_addr   = '0;
    if (state_q == RX_STORE)
      mem_addr = ADDR_W'(vec_cnt_q);
    else if (state_q == TX_READ)
      mem_addr = ADDR_W'(2*MATRIX_N) + ADDR_W'(vec_cnt_q);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= IDLE;
      vec_cnt_q    <= '0;
      cap_q        <= '0;
      rx_prev      <= 1'b0;
      tx_prev      <= 1'b0;
      md_prev      <= 1'b0;
      job_err      <= 1'b0;
      comm_op      <= 1'b0;
      comm_tx_data <= '0;
    end else begin
      state_q <= state_d;
      rx_prev <= comm_rx_complete;
      tx_prev <= comm_tx_complete;
      md_prev <= mult_done;
      case (state_q)
        IDLE: if (run) begin
          vec_cnt_q <= '0;
          job_err   <= 1'b0;
        end
        RX_WAIT: if (rx_rise) begin
          cap_q <= comm_rx_data;
          if (hdr_bad) job_err <= 1'b1;
        end
        RX_STORE: vec_cnt_q <= last_rx ? '0 : vec_cnt_q + 1'b1;
        TX_LATCH: comm_tx_data <= mem_rdata;
        TX_WAIT:  if (tx_rise && !last_tx) vec_cnt_q <= vec_cnt_q + 1'b1;
        default: ;
      endcase
      // comm_op follows the phase being entered and holds through DONE.
      case (state_d)
        IDLE, RX_ARM: comm_op <= 1'b0;
        TX_READ:      comm_op <= 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_matrix_io_sequencer.sv
// Directed job sequence with randomized vectors, timings and hold lengths against a transaction-level expectation.
module tb_matrix_io_sequencer;
  localparam int N = 4;
  localparam int DW = 8 + 32*N;

  logic          clk = 1'b0;
  logic          resetn, run, comm_rx_complete, comm_tx_complete, mult_done;
  logic [DW-1:0] comm_rx_data, mem_rdata, comm_tx_data, mem_wdata;
  logic          comm_op, comm_start, mem_we, mem_re, mult_start, busy, job_done, job_err;
  logic [3:0]    mem_addr;

  logic [DW-1:0] tbmem [16];
  int tests = 0, fails = 0;
  int n_we = 0, n_re = 0, n_cs = 0, n_ms = 0, n_jd = 0;

  matrix_io_sequencer #(.MATRIX_N(N), .HEADER(1)) dut (
    .clk(clk), .resetn(resetn), .run(run),
    .comm_rx_complete(comm_rx_complete), .comm_tx_complete(comm_tx_complete),
    .comm_rx_data(comm_rx_data), .comm_op(comm_op), .comm_start(comm_start),
    .comm_tx_data(comm_tx_data), .mem_we(mem_we), .mem_re(mem_re),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mult_start(mult_start), .mult_done(mult_done), .busy(busy),
    .job_done(job_done), .job_err(job_err)
  );

  always #5 clk = ~clk;

  // Vector memory: read data appears one cycle after mem_re, junk otherwise.
  always @(posedge clk)
    mem_rdata <= mem_re ? tbmem[mem_addr] : {$urandom, $urandom, $urandom, $urandom, 8'hA5};

  always @(negedge clk) begin
    if (mem_we) n_we++;
    if (mem_re) n_re++;
    if (comm_start) n_cs++;
    if (mult_start) n_ms++;
    if (job_done) n_jd++;
  end

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] rand_vec(input int hdr);
    logic [DW-1:0] v;
    v = {8'h00, $urandom, $urandom, $urandom, $urandom};
    v[DW-1 -: 8] = 8'(hdr);
    return v;
  endfunction

  task automatic wait_idle();
    int c;
    c = 0;
    while (busy !== 1'b0 && c < 100) begin
      @(negedge clk);
      c++;
    end
    chk("idle_timeout", busy, 0);
  endtask

  task automatic run_job(input int err_idx, input int err_hdr, input bit md_in_rx,
                         input bit run_in_mult, input int abort_tx, input int hold0);
    int b_we, b_re, b_cs, b_ms, b_jd, h;
    logic [DW-1:0] d;
    b_we = n_we; b_re = n_re; b_cs = n_cs; b_ms = n_ms; b_jd = n_jd;
    run = 1'b1;
    @(negedge clk);
    run = 1'b0;
    chk("start_pulse", comm_start, 1);
    chk("start_op_rx", comm_op, 0);
    chk("busy_on", busy, 1);
    chk("err_cleared", job_err, 0);
    for (int i = 0; i < 2*N; i++) begin
      @(negedge clk);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      if (md_in_rx && i == 2) begin
        mult_done = 1'b1;
        @(negedge clk);
        mult_done = 1'b0;
        @(negedge clk);
      end
      d = rand_vec((i == err_idx) ? err_hdr : int'($urandom_range(1, N)));
      comm_rx_data = d;
      comm_rx_complete = 1'b1;
      if (md_in_rx && i == 3) comm_tx_complete = 1'b1;
      @(negedge clk);
      if (i == err_idx) begin
        chk("err_no_we", mem_we, 0);
        chk("err_done", job_done, 1);
        chk("err_flag", job_err, 1);
        comm_rx_complete = 1'b0;
        @(negedge clk);
        chk("err_busy_off", busy, 0);
        chk("err_we_count", n_we - b_we, i);
        chk("err_jd_count", n_jd - b_jd, 1);
        return;
      end
      chk("we", mem_we, 1);
      chk("we_addr", mem_addr, i);
      chk("we_data", mem_wdata, d);
      @(negedge clk);
      if (i < 2*N-1) begin
        chk("rx_rearm", comm_start, 1);
        chk("rx_op", comm_op, 0);
      end else begin
        chk("mult_start", mult_start, 1);
      end
      h = (i == 0) ? hold0 : int'($urandom_range(0, 1));
      repeat (h) @(negedge clk);
      comm_rx_complete = 1'b0;
      comm_tx_complete = 1'b0;
      comm_rx_data = rand_vec(int'($urandom_range(0, 255)));
    end
    @(negedge clk);
    if (run_in_mult) begin
      run = 1'b1;
      @(negedge clk);
      run = 1'b0;
      @(negedge clk);
      chk("run_ignored", comm_start, 0);
      chk("run_busy", busy, 1);
    end
    for (int j = 0; j < N; j++) tbmem[2*N+j] = rand_vec(int'($urandom_range(1, N)));
    repeat ($urandom_range(0, 2)) @(negedge clk);
    chk("mult_wait_quiet", mem_re, 0);
    mult_done = 1'b1;
    for (int j = 0; j < N; j++) begin
      @(negedge clk);
      chk("re", mem_re, 1);
      chk("re_addr", mem_addr, 2*N+j);
      @(negedge clk);
      comm_tx_complete = 1'b0;
      if (j == 1) mult_done = 1'b0;
      @(negedge clk);
      chk("tx_start", comm_start, 1);
      chk("tx_op", comm_op, 1);
      chk("tx_data", comm_tx_data, tbmem[2*N+j]);
      @(negedge clk);
      if (j == abort_tx) begin
        b_cs = n_cs;
        b_we = n_we;
        resetn = 1'b0;
        #1;
        chk("rst_outs", {comm_op, comm_start, mem_we, mem_re, mem_addr, mult_start, busy, job_done, job_err}, 0);
        chk("rst_txdata", comm_tx_data, 0);
        chk("rst_wdata", mem_wdata, 0);
        mult_done = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        repeat (6) @(negedge clk);
        chk("rst_no_start", n_cs - b_cs, 0);
        chk("rst_no_we", n_we - b_we, 0);
        chk("rst_idle", busy, 0);
        return;
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
      chk("tx_hold", comm_tx_data, tbmem[2*N+j]);
      comm_tx_complete = 1'b1;
    end
    @(negedge clk);
    chk("job_done", job_done, 1);
    chk("job_err_low", job_err, 0);
    chk("done_busy", busy, 1);
    comm_tx_complete = 1'b0;
    mult_done = 1'b0;
    @(negedge clk);
    chk("busy_off", busy, 0);
    chk("job_done_pulse", job_done, 0);
    chk("we_count", n_we - b_we, 2*N);
    chk("re_count", n_re - b_re, N);
    chk("cs_count", n_cs - b_cs, 3*N);
    chk("ms_count", n_ms - b_ms, 1);
    chk("jd_count", n_jd - b_jd, 1);
  endtask

  initial begin
    resetn = 1'b0;
    run = 1'b0;
    comm_rx_complete = 1'b0;
    comm_tx_complete = 1'b0;
    mult_done = 1'b0;
    comm_rx_data = '0;
    for (int k = 0; k < 16; k++) tbmem[k] = '0;
    repeat (3) @(negedge clk);
    chk("reset_outs", {comm_op, comm_start, mem_we, mem_re, mem_addr, mult_start, busy, job_done, job_err}, 0);
    chk("reset_txdata", comm_tx_data, 0);
    chk("reset_wdata", mem_wdata, 0);
    resetn = 1'b1;
    repeat (4) @(negedge clk);
    chk("idle_no_start", n_cs, 0);
    chk("idle_busy", busy, 0);

    run_job(-1, 0, 1'b0, 1'b0, -1, 3);
    wait_idle();
    repeat ($urandom_range(1, 3)) @(negedge clk);
    run_job(-1, 0, 1'b1, 1'b1, -1, 0);
    wait_idle();
    run_job(3, 5, 1'b0, 1'b0, -1, 0);
    wait_idle();
    repeat (3) @(negedge clk);
    chk("err_sticky", job_err, 1);
    run_job(-1, 0, 1'b0, 1'b0, -1, 1);
    wait_idle();
    run_job(0, 0, 1'b0, 1'b0, -1, 0);
    wait_idle();
    run_job(-1, 0, 1'b0, 1'b0, 2, 0);
    wait_idle();
    for (int k = 0; k < 3; k++) begin
      repeat ($urandom_range(1, 3)) @(negedge clk);
      run_job(-1, 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), -1, int'($urandom_range(0, 3)));
      wait_idle();
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
